// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front-end for a single-port RAM.
// Deserialises {cmd[1:0], payload} frames from MOSI onto rx_data/rx_valid and
// serialises the RAM's read reply (tx_data/tx_valid) back on MISO, MSB first.
// Optional feature: define SPI_FRAME_ERR_EN to add the frame_err output, a
// one-cycle pulse when SS_n rises before the frame (or its read reply) ends.
module spi_slave_if #(
    parameter int DATA_W      = 8,
    parameter int TX_WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int TXC_W   = $clog2(DATA_W + 1);
    localparam int WC_W    = (TX_WAIT_MAX > 1) ? $clog2(TX_WAIT_MAX) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [TXC_W-1:0] TX_LAST   = TXC_W'(DATA_W - 1);
    localparam logic [TXC_W-1:0] TX_END    = TXC_W'(DATA_W);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(TX_WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shift_reg;
    logic               rd_addr_seen;
    logic               frame_done;   // rx_valid already issued this frame
    logic               reply_wait;   // waiting for the RAM's tx_valid
    logic               reply_busy;   // MISO reply in progress
    logic [WC_W-1:0]    wait_cnt;
    logic [TXC_W-1:0]   tx_cnt;
    logic [DATA_W-1:0]  tx_sreg;
`ifdef SPI_FRAME_ERR_EN
    logic               reply_done;   // all reply bits have been driven
`endif

    // The shift register is the RAM word; it only counts while rx_valid is high.
    assign rx_data = shift_reg;

    // Frame FSM: command check, bit shifting, RAM reply capture and MISO serialisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rd_addr_seen <= 1'b0;
            frame_done   <= 1'b0;
            reply_wait   <= 1'b0;
            reply_busy   <= 1'b0;
            wait_cnt     <= '0;
            tx_cnt       <= '0;
            tx_sreg      <= '0;
            MISO         <= 1'b0;
            rx_valid     <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            reply_done   <= 1'b0;
            frame_err    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            if (state != IDLE && SS_n) begin
                // Frame end or abort: drop everything in flight.
                state      <= IDLE;
                bit_cnt    <= '0;
                shift_reg  <= '0;
                frame_done <= 1'b0;
                reply_wait <= 1'b0;
                reply_busy <= 1'b0;
                wait_cnt   <= '0;
                tx_cnt     <= '0;
                MISO       <= 1'b0;
                // A read-data frame that reached the RAM has consumed the address.
                if (state == READ_DATA && frame_done)
                    rd_addr_seen <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
                reply_done <= 1'b0;
                frame_err  <= !frame_done || (state == READ_DATA && !reply_done);
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (!SS_n)
                            state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        if (!MOSI)
                            state <= WRITE;
                        else if (rd_addr_seen)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    default: begin
                        if (!frame_done) begin
                            shift_reg <= {shift_reg[FRAME_W-2:0], MOSI};
                            if (bit_cnt == LAST_BIT) begin
                                rx_valid   <= 1'b1;
                                frame_done <= 1'b1;
                                bit_cnt    <= '0;
                                if (state == READ_ADD)
                                    rd_addr_seen <= 1'b1;
                                if (state == READ_DATA)
                                    reply_wait <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end

                        if (reply_wait) begin
                            if (tx_valid) begin
                                MISO       <= tx_data[DATA_W-1];
                                tx_sreg    <= tx_data << 1;
                                tx_cnt     <= TXC_W'(1);
                                reply_wait <= 1'b0;
                                reply_busy <= 1'b1;
                            end else if (wait_cnt == WAIT_LAST) begin
                                // RAM never answered: give up, MISO stays low.
                                reply_wait   <= 1'b0;
                                rd_addr_seen <= 1'b0;
                            end else begin
                                wait_cnt <= wait_cnt + 1'b1;
                            end
                        end

                        if (reply_busy) begin
                            if (tx_cnt == TX_END) begin
                                MISO       <= 1'b0;
                                reply_busy <= 1'b0;
                                tx_cnt     <= '0;
                            end else begin
                                MISO    <= tx_sreg[DATA_W-1];
                                tx_sreg <= tx_sreg << 1;
                                tx_cnt  <= tx_cnt + 1'b1;
                                if (tx_cnt == TX_LAST) begin
                                    rd_addr_seen <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
                                    reply_done   <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: table-driven and randomized checks of spi_slave_if against a
// frame-level reference model (cycle positions computed from frame arithmetic).
module tb_spi_slave_if;

    localparam int DW  = 8;
    localparam int TXW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [DW+1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic          frame_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit seen  = 1'b0;   // model of the "read address already sent" flag

    spi_slave_if #(.DATA_W(DW), .TX_WAIT_MAX(TXW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one frame: SS_n low for 'low' edges, then one SS_n-high edge.
    // Edge 1 samples cmd, edges 2..11 the payload, rx_valid follows edge 11.
    // tx_valid is presented at edge 12+d; a reply is expected only if d < TXW.
    // rd_in: 1/0 forces the expected routing, -1 takes it from the model.
    // rst_at >= 0 pulses rst_n asynchronously after that edge and ends the frame.
    task automatic do_frame(input string nm, input int rd_in, input bit cmd,
                            input logic [9:0] pl, input int low, input int d,
                            input logic [7:0] txb, input int rst_at);
        bit rd, cpl, reply_ok, reply_done, e_rxv, e_miso;
        rd         = (rd_in < 0) ? (cmd && seen) : rd_in[0];
        cpl        = (low >= 12);
        reply_ok   = rd && cpl && (d < TXW);
        reply_done = reply_ok && (12 + d + 7 <= low - 1);
        for (int c = 0; c <= low; c++) begin
            SS_n     = (c < low) ? 1'b0 : 1'b1;
            MOSI     = (c == 1) ? cmd : (c >= 2 && c <= 11) ? pl[11-c] : 1'($urandom);
            tx_valid = (c < low) && (c == 12 + d);
            tx_data  = tx_valid ? txb : 8'($urandom);
            @(posedge clk); #1;
            e_rxv  = (c == 11) && cpl;
            e_miso = reply_ok && c < low && c >= 12 + d && c <= 12 + d + 7 ? txb[7-(c-12-d)] : 1'b0;
            chk($sformatf("%s rx_valid@%0d", nm, c), 32'(rx_valid), 32'(e_rxv));
            chk($sformatf("%s MISO@%0d", nm, c), 32'(MISO), 32'(e_miso));
            if (e_rxv)
                chk($sformatf("%s rx_data", nm), 32'(rx_data), 32'(pl));
`ifdef SPI_FRAME_ERR_EN
            chk($sformatf("%s frame_err@%0d", nm, c), 32'(frame_err),
                32'((c == low) && (!cpl || (rd && !reply_done))));
`endif
            if (c == rst_at) begin
                tx_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk($sformatf("%s async MISO", nm), 32'(MISO), 32'd0);
                chk($sformatf("%s async rx_valid", nm), 32'(rx_valid), 32'd0);
                chk($sformatf("%s async rx_data", nm), 32'(rx_data), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                SS_n  = 1'b1;
                @(posedge clk); #1;
                seen = 1'b0;
                return;
            end
        end
        tx_valid = 1'b0;
        if (cpl && cmd)
            seen = !rd;  // address frame arms the read, data frame consumes it
    endtask

    typedef struct {
        string      nm;
        bit         cmd;
        logic [9:0] pl;
        int         low;
        int         d;
        logic [7:0] txb;
        bit         exp_rd;   // expected to be routed as a read-data frame
    } vec_t;

    vec_t tbl[14];

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset MISO", 32'(MISO), 32'd0);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset rx_data", 32'(rx_data), 32'd0);
`ifdef SPI_FRAME_ERR_EN
        chk("reset frame_err", 32'(frame_err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        tbl[0]  = '{"wr_addr",     1'b0, 10'h0A5, 13, 99,  8'h00, 1'b0};
        tbl[1]  = '{"rd_addr",     1'b1, 10'h23C, 13, 99,  8'h00, 1'b0};
        tbl[2]  = '{"rd_data",     1'b1, 10'h300, 22, 1,   8'hC3, 1'b1};
        tbl[3]  = '{"rd_again",    1'b1, 10'h2AA, 22, 1,   8'hFF, 1'b0};
        tbl[4]  = '{"rd_data_d0",  1'b1, 10'h35A, 21, 0,   8'h5A, 1'b1};
        tbl[5]  = '{"wr_abort",    1'b0, 10'h1F0, 7,  99,  8'h00, 1'b0};
        tbl[6]  = '{"rd_addr2",    1'b1, 10'h211, 13, 99,  8'h00, 1'b0};
        tbl[7]  = '{"rd_noreply",  1'b1, 10'h3EE, 19, 99,  8'h00, 1'b1};
        tbl[8]  = '{"rd_after_to", 1'b1, 10'h2C0, 13, 99,  8'h00, 1'b0};
        tbl[9]  = '{"rd_last_win", 1'b1, 10'h301, 24, TXW-1, 8'h81, 1'b1};
        tbl[10] = '{"chk_abort",   1'b0, 10'h000, 1,  99,  8'h00, 1'b0};
        tbl[11] = '{"mismatch",    1'b0, 10'h3FF, 13, 99,  8'h00, 1'b0};
        tbl[12] = '{"b2b_addr",    1'b0, 10'h011, 12, 99,  8'h00, 1'b0};
        tbl[13] = '{"b2b_data",    1'b0, 10'h155, 12, 99,  8'h00, 1'b0};

        foreach (tbl[i])
            do_frame(tbl[i].nm, int'(tbl[i].exp_rd), tbl[i].cmd, tbl[i].pl,
                     tbl[i].low, tbl[i].d, tbl[i].txb, -1);

        // Late tx_valid, one cycle past the window, must be ignored.
        do_frame("late_addr", 0, 1'b1, 10'h200, 13, 99, 8'h00, -1);
        do_frame("late_data", 1, 1'b1, 10'h300, 22, TXW, 8'hFF, -1);
        // Abort in the middle of a reply consumes the address.
        do_frame("part_addr", 0, 1'b1, 10'h201, 13, 99, 8'h00, -1);
        do_frame("part_data", 1, 1'b1, 10'h302, 17, 1, 8'hF0, -1);
        do_frame("part_next", 0, 1'b1, 10'h203, 13, 99, 8'h00, -1);
        // Async reset while a reply is on MISO (bit 1 of 8'hFF showing), and
        // while rx_valid is high.
        do_frame("rst_reply", 1, 1'b1, 10'h304, 22, 0, 8'hFF, 13);
        do_frame("rst_rxv", 0, 1'b0, 10'h0F0, 13, 99, 8'h00, 11);
        do_frame("post_rst", 0, 1'b1, 10'h205, 13, 99, 8'h00, -1);

        // Random frames checked against the model's view of rd_addr_seen.
        for (int n = 0; n < 60; n++) begin
            bit         cmd;
            int         low, d;
            cmd = 1'($urandom);
            if ($urandom_range(4, 0) == 0)
                low = $urandom_range(11, 1);
            else
                low = 12 + $urandom_range(16, 1);
            d = $urandom_range(TXW + 1, 0);
            do_frame($sformatf("rnd%0d", n), -1, cmd, 10'($urandom), low, d,
                     8'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
